// File: rtl/cic_pkg.sv
// cic_pkg: shared widths, FIFO entry type and output conversion
// helpers for the multi-channel CIC decimator.
package cic_pkg;

    localparam int ENT_CH_W   = 3;
    localparam int ENT_DATA_W = 32;

    typedef struct packed {
        logic [ENT_CH_W-1:0]   ch;
        logic [ENT_DATA_W-1:0] data;
    } fifo_entry_t;

    function automatic int acc_w(
        input int order,
        input int in_w,
        input int max_log2
    );
        return in_w + order * max_log2;
    endfunction

    // Round half-up on the dropped bits, then clamp to out_w signed.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] v,
        input int                 trunc,
        input int                 out_w
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (trunc > 0) begin
            r = (v + (64'sd1 <<< (trunc - 1))) >>> trunc;
        end else begin
            r = v <<< (-trunc);
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/cic_out_fifo.sv
// cic_out_fifo: 2-entry synchronous valid/ready FIFO, head always
// in e0 so the read data is a plain register.
module cic_out_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] e0_q;
    logic [W-1:0] e0_d;
    logic [W-1:0] e1_q;
    logic [W-1:0] e1_d;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         do_pop;
    logic         do_push;

    assign empty = (cnt_q == 2'd0);
    assign full  = (cnt_q == 2'd2);
    assign dout  = e0_q;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        if (do_pop) begin
            if (cnt_q == 2'd2) begin
                e0_d = e1_q;
            end
            cnt_d = cnt_q - 2'd1;
        end
        if (do_push) begin
            if (cnt_d == 2'd0) begin
                e0_d = din;
            end else begin
                e1_d = din;
            end
            cnt_d = cnt_d + 2'd1;
        end
        if (clear) begin
            e0_d  = '0;
            e1_d  = '0;
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cic_decim_mc.sv
// cic_decim_mc: multi-channel CIC decimator, runtime power-of-two rate,
// gain normalised by input pre-scale, rounded/saturated into a FIFO.
module cic_decim_mc
    import cic_pkg::*;
#(
    parameter int ORDER        = 3,
    parameter int NUM_CH       = 2,
    parameter int MAX_LOG2_DEC = 6,
    parameter int IN_W         = 8,
    parameter int IN_FRAC      = 7,
    parameter int OUT_W        = 16,
    parameter int OUT_FRAC     = 15,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DL_W        = $clog2(MAX_LOG2_DEC + 1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [DL_W-1:0]         dec_log2,
    input  logic                    in_valid,
    input  logic [CH_W-1:0]         in_ch,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    overflow
);

    localparam int ACC_W = acc_w(ORDER, IN_W, MAX_LOG2_DEC);
    localparam int TRUNC = ACC_W - (IN_W - IN_FRAC) - OUT_FRAC;
    localparam int CNT_W = MAX_LOG2_DEC;

    typedef logic signed [ACC_W-1:0] acc_t;

    acc_t             integ_q [NUM_CH][ORDER];
    acc_t             integ_d [NUM_CH][ORDER];
    acc_t             dly_q   [NUM_CH][ORDER];
    acc_t             dly_d   [NUM_CH][ORDER];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];
    logic [DL_W-1:0]  dec_r_q;
    logic [DL_W-1:0]  dec_r_d;
    logic             pend_q;
    logic             pend_d;
    logic             overflow_q;
    logic             overflow_d;

    logic [DL_W-1:0]  dec_in;
    logic [DL_W-1:0]  dec_eff;
    logic [CNT_W-1:0] last;
    logic [CH_W-1:0]  ch;
    logic             ch_ok;
    logic             acc;
    logic             hit;
    logic             push;
    logic             drop;
    logic             full;
    logic             empty;
    acc_t             x;
    acc_t             y [ORDER+1];
    fifo_entry_t      push_e;
    fifo_entry_t      head;
    logic             head_unused;

    // Shared datapath: only the addressed channel is live each cycle.
    always_comb begin
        dec_in  = (int'(dec_log2) > MAX_LOG2_DEC) ?
                  DL_W'(MAX_LOG2_DEC) : dec_log2;
        dec_eff = pend_q ? dec_in : dec_r_q;
        last    = CNT_W'((1 << dec_eff) - 1);
        ch_ok   = int'(in_ch) < NUM_CH;
        ch      = ch_ok ? in_ch : '0;
        acc     = in_valid && enable && ch_ok && !clear;
        hit     = (cnt_q[ch] == last);
        push    = acc && hit;
        drop    = push && full && !out_ready;
        x       = acc_t'(in_data) <<<
                  (ORDER * (MAX_LOG2_DEC - int'(dec_eff)));
        y[0]    = integ_q[ch][ORDER-1];
        for (int k = 1; k <= ORDER; k++) begin
            y[k] = y[k-1] - dly_q[ch][k-1];
        end
        push_e.ch   = ENT_CH_W'(ch);
        push_e.data = ENT_DATA_W'($signed(OUT_W'(
                      round_sat(64'(y[ORDER]), TRUNC, OUT_W))));
    end

    always_comb begin
        integ_d    = integ_q;
        dly_d      = dly_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q || drop;
        pend_d     = 1'b0;
        dec_r_d    = (clear || pend_q) ? dec_in : dec_r_q;
        if (acc) begin
            integ_d[ch][0] = integ_q[ch][0] + x;
            for (int k = 1; k < ORDER; k++) begin
                integ_d[ch][k] = integ_q[ch][k] + integ_q[ch][k-1];
            end
            cnt_d[ch] = hit ? '0 : cnt_q[ch] + 1'b1;
            if (hit) begin
                for (int k = 0; k < ORDER; k++) begin
                    dly_d[ch][k] = y[k];
                end
            end
        end
        if (clear) begin
            integ_d    = '{default: '0};
            dly_d      = '{default: '0};
            cnt_d      = '{default: '0};
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            integ_q    <= '{default: '0};
            dly_q      <= '{default: '0};
            cnt_q      <= '{default: '0};
            dec_r_q    <= '0;
            pend_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            integ_q    <= integ_d;
            dly_q      <= dly_d;
            cnt_q      <= cnt_d;
            dec_r_q    <= dec_r_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
        end
    end

    cic_out_fifo #(
        .W($bits(fifo_entry_t))
    ) u_fifo (
        .clk   (clk),
        .resetn(resetn),
        .clear (clear),
        .push  (push),
        .din   (push_e),
        .pop   (out_ready),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign out_valid   = !empty;
    assign out_ch      = CH_W'(head.ch);
    assign out_data    = OUT_W'(head.data);
    assign overflow    = overflow_q;
    assign head_unused = ^head;

endmodule

// File: tb/tb_cic_decim_mc.sv
// tb_cic_decim_mc: directed stimulus with a queue scoreboard; expected
// outputs come from the closed-form DC step response of a 3rd-order CIC.
module tb_cic_decim_mc;

    logic              clk       = 1'b0;
    logic              resetn    = 1'b0;
    logic              clear     = 1'b0;
    logic              enable    = 1'b1;
    logic [2:0]        dec_log2  = 3'd2;
    logic              in_valid  = 1'b0;
    logic [0:0]        in_ch     = 1'b0;
    logic signed [7:0] in_data   = 8'sd0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [0:0]        out_ch;
    logic signed [15:0] out_data;
    logic              overflow;

    int          checks   = 0;
    int          failures = 0;
    logic [16:0] expq[$];
    int          pc[2];
    int          pk[2];
    int          dq = 2;
    int          rr = 4;
    int          rates[4] = '{0, 3, 6, 7};
    int          lens[4]  = '{8, 48, 256, 128};

    cic_decim_mc dut (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (clear),
        .enable   (enable),
        .dec_log2 (dec_log2),
        .in_valid (in_valid),
        .in_ch    (in_ch),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .out_data (out_data),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // k-th output for constant input v since clear: third difference of
    // C(kR-1,3), scaled by the pre-shift, then rounded and saturated.
    function automatic logic [15:0] exp_dc(
        input logic [7:0] v,
        input int         d,
        input int         k
    );
        longint s[4];
        longint r;
        longint y;
        longint val;
        longint o;
        r = longint'(1) << d;
        for (int i = 0; i < 4; i++) begin
            longint n;
            n = longint'(k - i) * r - 1;
            s[i] = (k - i <= 0) ? 0 : n * (n - 1) * (n - 2) / 6;
        end
        y   = s[0] - 3 * s[1] + 3 * s[2] - s[3];
        val = longint'($signed(v)) * (longint'(1) << (18 - 3 * d)) * y;
        o   = (val + 512) >>> 10;
        if (o > 32767) o = 32767;
        if (o < -32768) o = -32768;
        return o[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, req);
        end
    endtask

    task automatic set_rate(input int d);
        dec_log2 = d[2:0];
        dq       = (d > 6) ? 6 : d;
        rr       = 1 << dq;
    endtask

    task automatic restart();
        pc = '{0, 0};
        pk = '{0, 0};
    endtask

    task automatic do_clear(input logic with_sample);
        clear    = 1'b1;
        in_valid = with_sample;
        in_ch    = 1'b0;
        in_data  = 8'sh40;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        restart();
    endtask

    task automatic send(input int ch, input logic [7:0] v);
        in_valid = 1'b1;
        in_ch    = ch[0];
        in_data  = v;
        if (enable) begin
            if (pc[ch] == rr - 1) begin
                pc[ch] = 0;
                pk[ch]++;
                if (out_ready || expq.size() < 2)
                    expq.push_back({ch[0], exp_dc(v, dq, pk[ch])});
            end else begin
                pc[ch]++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, expq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected got ch=%0d data=%h want none",
                         out_ch, out_data);
            end else begin
                chk("out", {15'd0, out_ch, out_data},
                    {15'd0, expq.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_ovf", overflow, 0);
        #11 resetn = 1'b1;
        @(posedge clk);
        #1;
        restart();

        for (int i = 0; i < 24; i++) send(0, 8'h40);
        drain("dc");

        set_rate(2);
        do_clear(1'b0);
        for (int i = 0; i < 20; i++) send(0, 8'h80);
        drain("fs_neg");
        do_clear(1'b0);
        for (int i = 0; i < 20; i++) send(0, 8'h7F);
        drain("fs_pos");
        chk("fs_ovf", overflow, 0);

        for (int r = 0; r < 4; r++) begin
            set_rate(rates[r]);
            do_clear(1'b0);
            for (int i = 0; i < lens[r]; i++) send(0, 8'h40);
            drain("rate");
        end

        set_rate(2);
        do_clear(1'b0);
        for (int i = 0; i < 16; i++) begin
            send(0, 8'h40);
            send(1, 8'hC0);
        end
        drain("chan");

        do_clear(1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(0, 8'h40);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_ovf", overflow, 1);
        chk("bp_valid", out_valid, 1);
        enable    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 8'h40);
        drain("bp");
        repeat (3) @(posedge clk);
        #1;
        chk("bp_empty", out_valid, 0);
        enable = 1'b1;
        do_clear(1'b0);
        chk("clr_ovf", overflow, 0);
        chk("clr_valid", out_valid, 0);

        for (int i = 0; i < 2; i++) send(0, 8'h40);
        do_clear(1'b1);
        for (int i = 0; i < 3; i++) send(0, 8'h40);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_quiet", out_valid, 0);
        send(0, 8'h40);
        chk("mid_lat", out_valid, 1);
        drain("mid");

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 8'h40);
        chk("ar_pre", out_valid, 1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data, 0);
        chk("ar_ovf", overflow, 0);
        expq.delete();
        restart();
        set_rate(0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) send(0, 8'h40);
        dec_log2 = 3'd3;
        for (int i = 0; i < 4; i++) send(0, 8'h40);
        drain("ar");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
